// File: rtl/encoder_ctrl.sv
// -----------------------------------------------------------------------------
// encoder_ctrl
//
// Single-clock quadrature encoder controller. canalA/canalB are brought into
// the clk domain with a 2-FF synchronizer, debounced by a per-channel run-length
// filter evaluated on a sample tick, and decoded by a DISABLED/ACQUIRE/RUN state
// machine into +1/-1 steps on a signed position counter. A request/valid read
// port returns atomic snapshots of the position and of the change since the
// previous snapshot.
//
// Optional feature: define ENCODER_CTRL_ERR_EN to build the illegal-transition
// counter (err_cnt, saturating at 255, cleared only by reset). Without it,
// err_cnt is tied to 0 and no detection logic exists.
//
// Parameters
//   CLK_HZ     clock frequency in Hz
//   SAMPLE_HZ  sample tick rate in Hz (divider N = CLK_HZ/SAMPLE_HZ, N >= 2)
//   POS_W      position / delta width, two's complement
//   FILT       consecutive differing samples needed to accept a level (1..15)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   canalA, canalB    encoder channels, asynchronous to clk
//   enable            1 = decode, 0 = hold position
//   clr               synchronous clear of position and read reference
//   rd_req            snapshot request, sampled every clk
//   rd_valid          one-cycle strobe qualifying rd_pos / rd_delta
//   rd_pos, rd_delta  snapshot of position and change since last snapshot
//   pos               live position
//   giroPositivo/Negativo  one-clk pulse per +1 / -1 step
//   dir               direction of last accepted step (1 = positive)
//   err_cnt           illegal-transition count
//   dbg_state         current FSM state (0 DISABLED, 1 ACQUIRE, 2 RUN)
//
// Read handshake: rd_req has no ready; a request in cycle t always produces
// rd_valid in cycle t+1 with the snapshot of pos as registered in cycle t.
// -----------------------------------------------------------------------------
module encoder_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 500,
  parameter int POS_W     = 16,
  parameter int FILT      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             canalA,
  input  logic             canalB,
  input  logic             enable,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [POS_W-1:0] rd_pos,
  output logic [POS_W-1:0] rd_delta,
  output logic [POS_W-1:0] pos,
  output logic             giroPositivo,
  output logic             giroNegativo,
  output logic             dir,
  output logic [7:0]       err_cnt,
  output logic [1:0]       dbg_state
);

  localparam int N     = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Sample tick: a clock enable, asserted one clk when the counter hits N-1.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // 2-FF synchronizer, bit 1 = A, bit 0 = B.
  // ---------------------------------------------------------------------------
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {canalA, canalB};
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-length filter: a new level is accepted on the FILT-th consecutive tick
  // that sees it; any tick that agrees with the filtered level restarts the run.
  // ---------------------------------------------------------------------------
  logic [1:0] filt_q, filt_d;
  logic [3:0] run_q [2];
  logic [3:0] run_d [2];

  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (run_q[i] == 4'(FILT - 1)) begin
            filt_d[i] = sync2_q[i];
            run_d[i]  = '0;
          end else begin
            run_d[i] = run_q[i] + 4'd1;
          end
        end else begin
          run_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      run_q[0] <= '0;
      run_q[1] <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   acq_load;
  logic   decode_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_DISABLED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_ACQUIRE;
        ST_ACQUIRE:  if (tick) state_d = ST_RUN;
        ST_RUN:      state_d = ST_RUN;
        default:     state_d = ST_DISABLED;
      endcase
    end
  end

  // enable is rechecked so the cycle in which it drops never decodes.
  always_comb begin
    acq_load  = (state_q == ST_ACQUIRE) && enable && tick;
    decode_en = (state_q == ST_RUN) && enable && tick;
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Quadrature decode against the previously sampled AB (A is the MSB).
  // ---------------------------------------------------------------------------
  logic [1:0] prev_ab_q, prev_ab_d;
  logic       step_fwd, step_rev;

  always_comb begin
    prev_ab_d = prev_ab_q;
    if (acq_load || decode_en) prev_ab_d = filt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_ab_q <= '0;
    else        prev_ab_q <= prev_ab_d;
  end

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    if (decode_en) begin
      case ({prev_ab_q, filt_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position, step pulses and read snapshots. The snapshot always uses the
  // registered pos; clr overrides both a same-cycle step and the new
  // last_read value.
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] last_read_q, last_read_d;
  logic [POS_W-1:0] rd_pos_q, rd_pos_d;
  logic [POS_W-1:0] rd_delta_q, rd_delta_d;
  logic             rd_valid_q, rd_valid_d;
  logic             gp_q, gp_d, gn_q, gn_d, dir_q, dir_d;

  always_comb begin
    pos_d       = pos_q;
    last_read_d = last_read_q;
    rd_pos_d    = rd_pos_q;
    rd_delta_d  = rd_delta_q;
    rd_valid_d  = rd_req;
    gp_d        = 1'b0;
    gn_d        = 1'b0;
    dir_d       = dir_q;
    if (rd_req) begin
      rd_pos_d    = pos_q;
      rd_delta_d  = pos_q - last_read_q;
      last_read_d = pos_q;
    end
    if (clr) begin
      pos_d       = '0;
      last_read_d = '0;
    end else if (step_fwd) begin
      pos_d = pos_q + POS_W'(1);
      gp_d  = 1'b1;
      dir_d = 1'b1;
    end else if (step_rev) begin
      pos_d = pos_q - POS_W'(1);
      gn_d  = 1'b1;
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      last_read_q <= '0;
      rd_pos_q    <= '0;
      rd_delta_q  <= '0;
      rd_valid_q  <= 1'b0;
      gp_q        <= 1'b0;
      gn_q        <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      last_read_q <= last_read_d;
      rd_pos_q    <= rd_pos_d;
      rd_delta_q  <= rd_delta_d;
      rd_valid_q  <= rd_valid_d;
      gp_q        <= gp_d;
      gn_q        <= gn_d;
      dir_q       <= dir_d;
    end
  end

  assign pos          = pos_q;
  assign rd_pos       = rd_pos_q;
  assign rd_delta     = rd_delta_q;
  assign rd_valid     = rd_valid_q;
  assign giroPositivo = gp_q;
  assign giroNegativo = gn_q;
  assign dir          = dir_q;

  // ---------------------------------------------------------------------------
  // Illegal-transition counter (both bits changed between samples in RUN).
  // ---------------------------------------------------------------------------
`ifdef ENCODER_CTRL_ERR_EN
  logic [7:0] err_q, err_d;
  logic       illegal;

  always_comb begin
    illegal = decode_en && ((prev_ab_q ^ filt_q) == 2'b11);
    err_d   = err_q;
    if (illegal && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encoder_ctrl
//
// Directed bench for encoder_ctrl at CLK_HZ=1000, SAMPLE_HZ=100 (tick every
// 10 clk), FILT=3, POS_W=16. Stimulus pushes expected step pulses and read
// snapshots into queues; a negedge monitor pops and compares them whenever the
// DUT pulses giroPositivo/giroNegativo or rd_valid. Scenario checks on pos,
// dir and err_cnt are made directly from the stimulus process.
// -----------------------------------------------------------------------------
module tb_encoder_ctrl;

  localparam int POS_W = 16;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             canalA = 1'b0;
  logic             canalB = 1'b0;
  logic             enable = 1'b0;
  logic             clr = 1'b0;
  logic             rd_req = 1'b0;
  logic             rd_valid;
  logic [POS_W-1:0] rd_pos;
  logic [POS_W-1:0] rd_delta;
  logic [POS_W-1:0] pos;
  logic             giroPositivo;
  logic             giroNegativo;
  logic             dir;
  logic [7:0]       err_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT tick counter modulo 10.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  encoder_ctrl #(
    .CLK_HZ   (1000),
    .SAMPLE_HZ(100),
    .POS_W    (POS_W),
    .FILT     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .canalA      (canalA),
    .canalB      (canalB),
    .enable      (enable),
    .clr         (clr),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_pos      (rd_pos),
    .rd_delta    (rd_delta),
    .pos         (pos),
    .giroPositivo(giroPositivo),
    .giroNegativo(giroNegativo),
    .dir         (dir),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [2*POS_W-1:0] exp_q[$];   // {rd_pos, rd_delta}
  logic [POS_W:0]     step_q[$];  // {fwd, pos after step}
  logic [2*POS_W-1:0] mon_rd;
  logic [POS_W:0]     mon_st;

`ifdef ENCODER_CTRL_ERR_EN
  localparam logic [7:0] EXP_ERR = 8'd1;
`else
  localparam logic [7:0] EXP_ERR = 8'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        check("rd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_rd = exp_q.pop_front();
          check("rd_pos", 32'(rd_pos), 32'(mon_rd[2*POS_W-1:POS_W]));
          check("rd_delta", 32'(rd_delta), 32'(mon_rd[POS_W-1:0]));
        end
      end
      if (giroPositivo || giroNegativo) begin
        check("step_expected", 32'(step_q.size() != 0), 32'd1);
        if (step_q.size() != 0) begin
          mon_st = step_q.pop_front();
          check("giro_pos", 32'(giroPositivo), 32'(mon_st[POS_W]));
          check("giro_neg", 32'(giroNegativo), 32'(!mon_st[POS_W]));
          check("step_dir", 32'(dir), 32'(mon_st[POS_W]));
          check("step_pos", 32'(pos), 32'(mon_st[POS_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ab(input logic [1:0] ab, input int hold);
    {canalA, canalB} = ab;
    repeat (hold) @(negedge clk);
  endtask

  task automatic step_to(input logic [1:0] ab, input logic fwd, input logic [POS_W-1:0] p);
    step_q.push_back({fwd, p});
    drive_ab(ab, 50);
  endtask

  task automatic read_snap(input logic [POS_W-1:0] p, input logic [POS_W-1:0] d);
    exp_q.push_back({p, d});
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pos"}, 32'(pos), 32'd0);
    check({tag, "_rd_pos"}, 32'(rd_pos), 32'd0);
    check({tag, "_rd_delta"}, 32'(rd_delta), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_giro_pos"}, 32'(giroPositivo), 32'd0);
    check({tag, "_giro_neg"}, 32'(giroNegativo), 32'd0);
    check({tag, "_dir"}, 32'(dir), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Forward sequence
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("acquired_run_state", 32'(dbg_state), 32'd2);
    step_to(2'b10, 1'b1, 16'd1);
    step_to(2'b11, 1'b1, 16'd2);
    step_to(2'b01, 1'b1, 16'd3);
    step_to(2'b00, 1'b1, 16'd4);
    check("fwd_pos", 32'(pos), 32'd4);
    check("fwd_dir", 32'(dir), 32'd1);

    // Clear, then one reverse step wraps to 0xFFFF
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_pos", 32'(pos), 32'd0);
    step_to(2'b01, 1'b0, 16'hFFFF);
    check("rev_wrap_pos", 32'(pos), 32'hFFFF);
    check("rev_dir", 32'(dir), 32'd0);
    step_to(2'b00, 1'b1, 16'h0000);

    // Short glitch rejected by the filter
    drive_ab(2'b10, 15);
    drive_ab(2'b00, 50);
    check("glitch_pos", 32'(pos), 32'd0);

    // Illegal 00->11
    drive_ab(2'b11, 50);
    check("illegal_pos", 32'(pos), 32'd0);
    check("illegal_err_cnt", 32'(err_cnt), 32'(EXP_ERR));

    // Read handshake
    step_to(2'b01, 1'b1, 16'd1);
    step_to(2'b00, 1'b1, 16'd2);
    step_to(2'b10, 1'b1, 16'd3);
    step_to(2'b11, 1'b1, 16'd4);
    step_to(2'b01, 1'b1, 16'd5);
    read_snap(16'd5, 16'd5);
    step_to(2'b00, 1'b1, 16'd6);
    step_to(2'b10, 1'b1, 16'd7);
    read_snap(16'd7, 16'd2);

    // clr in the exact decode cycle of a +1 step (10->11). Driving at tick
    // phase 0, the filter accepts on the third tick and the decode tick falls
    // 39 cycles later.
    @(negedge clk);
    for (int i = 0; i < 10 && (cyc % 10) != 0; i++) @(negedge clk);
    drive_ab(2'b11, 39);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_vs_step_pos", 32'(pos), 32'd0);
    check("clr_vs_step_giro", 32'(giroPositivo), 32'd0);
    repeat (20) @(negedge clk);
    step_to(2'b01, 1'b1, 16'd1);
    read_snap(16'd1, 16'd1);

    // Edges while disabled are discarded
    enable = 1'b0;
    drive_ab(2'b00, 50);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    check("reenable_pos", 32'(pos), 32'd1);
    step_to(2'b10, 1'b1, 16'd2);
    step_to(2'b11, 1'b1, 16'd3);

    // Reset mid-motion at pos = 3
    drive_ab(2'b01, 5);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    {canalA, canalB} = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_pos", 32'(pos), 32'd0);
    check("post_reset_err", 32'(err_cnt), 32'd0);
    step_to(2'b01, 1'b1, 16'd1);
    check("post_reset_step_pos", 32'(pos), 32'd1);

    repeat (10) @(negedge clk);
    check("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("step_queue_drained", 32'(step_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
